// File: rtl/smi_axi_write_id_pool_if.sv
// Bundle of the allocation, AXI B and SMI response signals
// of the write ID pool.
interface smi_axi_write_id_pool_if #(
  parameter int AxiIdWidth = 4,
  parameter int DataWidth  = 64
);
  logic                  allocReq;
  logic [15:0]           allocTag;
  logic                  allocAck;
  logic [AxiIdWidth-1:0] allocId;
  logic                  axiBValid;
  logic                  axiBReady;
  logic [AxiIdWidth-1:0] axiBId;
  logic [1:0]            axiBResp;
  logic                  smiRespReady;
  logic [7:0]            smiRespEofc;
  logic [DataWidth-1:0]  smiRespData;
  logic                  smiRespStop;
  logic [AxiIdWidth:0]   inFlightCount;
  logic                  errId;

  modport slave (
    input  allocReq, allocTag,
    input  axiBValid, axiBId, axiBResp,
    input  smiRespStop,
    output allocAck, allocId, axiBReady,
    output smiRespReady, smiRespEofc, smiRespData,
    output inFlightCount, errId
  );

  modport master (
    output allocReq, allocTag,
    output axiBValid, axiBId, axiBResp,
    output smiRespStop,
    input  allocAck, allocId, axiBReady,
    input  smiRespReady, smiRespEofc, smiRespData,
    input  inFlightCount, errId
  );
endinterface

// File: rtl/smi_axi_write_id_pool.sv
// AXI write ID pool: allocates IDs, binds SMI tags, and turns
// B responses into SMI write-response frames.
module smi_axi_write_id_pool #(
  parameter int DataIndexSize = 3,
  parameter int AxiIdWidth    = 4,
  parameter int MaxWriteIds   = 16,
  parameter bit InOrderResp   = 1'b0
) (
  input logic clk,
  input logic srst,
  smi_axi_write_id_pool_if.slave bus
);
  localparam int DataWidth = 8 << DataIndexSize;
  localparam int NumIds    = 1 << AxiIdWidth;
  localparam int PW        = (MaxWriteIds > 1) ? $clog2(MaxWriteIds) : 1;
  localparam int Depth     = 1 << PW;
  localparam int CW        = AxiIdWidth + 1;

  typedef logic [AxiIdWidth-1:0] id_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef enum logic {Init, Run} state_e;

  state_e               state_q;
  id_t                  init_q;
  logic [NumIds-1:0]    busy_q, busy_d;
  logic [NumIds-1:0]    done_q, done_d;
  logic [15:0]          tag_q  [NumIds];
  logic [1:0]           stat_q [NumIds];
  id_t                  free_q [Depth];
  ptr_t                 frd_q, fwr_q;
  logic [PW:0]          fcnt_q;
  id_t                  ord_q  [Depth];
  ptr_t                 ord_rd_q, ord_wr_q;
  logic                 rdy_q;
  logic [DataWidth-1:0] data_q;
  logic [CW-1:0]        infl_q;
  logic                 err_q;

  logic                 run, ack, alloc;
  id_t                  alloc_id;
  logic                 b_fire, b_ok;
  logic                 cand_vld, load, push;
  id_t                  cand_id, push_id;
  logic [DataWidth-1:0] frame;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(MaxWriteIds - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run      = (state_q == Run);
  assign ack      = run && (fcnt_q != '0);
  assign alloc    = ack && bus.allocReq;
  assign alloc_id = free_q[frd_q];
  assign b_fire   = run && bus.axiBValid;
  assign b_ok     = busy_q[bus.axiBId] && !done_q[bus.axiBId];
  assign load     = !rdy_q && cand_vld;
  assign push     = !run || load;
  assign push_id  = run ? cand_id : init_q;

  // In-order mode: the order FIFO holds exactly the in-flight IDs
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    if (InOrderResp) begin
      cand_id  = ord_q[ord_rd_q];
      cand_vld = (infl_q != '0) && done_q[cand_id];
    end else begin
      for (int i = MaxWriteIds - 1; i >= 0; i--) begin
        if (done_q[i]) begin
          cand_vld = 1'b1;
          cand_id  = id_t'(i);
        end
      end
    end
  end

  always_comb begin
    frame        = '0;
    frame[7:0]   = 8'hFE;
    frame[9:8]   = stat_q[cand_id];
    frame[31:16] = tag_q[cand_id];
  end

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (alloc) busy_d[alloc_id] = 1'b1;
    if (b_fire && b_ok) done_d[bus.axiBId] = 1'b1;
    if (load) begin
      busy_d[cand_id] = 1'b0;
      done_d[cand_id] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= Init;
      init_q   <= '0;
      busy_q   <= '0;
      done_q   <= '0;
      frd_q    <= '0;
      fwr_q    <= '0;
      fcnt_q   <= '0;
      ord_rd_q <= '0;
      ord_wr_q <= '0;
      rdy_q    <= 1'b0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q  <= b_fire && !b_ok;
      busy_q <= busy_d;
      done_q <= done_d;
      if (!run) begin
        init_q <= init_q + 1'b1;
        if (init_q == id_t'(MaxWriteIds - 1)) state_q <= Run;
      end
      if (push) fwr_q <= inc(fwr_q);
      if (alloc) frd_q <= inc(frd_q);
      fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(alloc);
      infl_q <= infl_q + CW'(alloc) - CW'(load);
      if (InOrderResp && alloc) ord_wr_q <= inc(ord_wr_q);
      if (InOrderResp && load) ord_rd_q <= inc(ord_rd_q);
      if (rdy_q) begin
        if (!bus.smiRespStop) rdy_q <= 1'b0;
      end else if (cand_vld) begin
        rdy_q <= 1'b1;
      end
    end
  end

  // Storage without reset; validity is tracked by the pointers and bits above
  always_ff @(posedge clk) begin
    if (!srst && push) free_q[fwr_q] <= push_id;
    if (!srst && InOrderResp && alloc) ord_q[ord_wr_q] <= alloc_id;
    if (alloc) tag_q[alloc_id] <= bus.allocTag;
    if (b_fire && b_ok) stat_q[bus.axiBId] <= bus.axiBResp;
    if (load) data_q <= frame;
  end

  assign bus.allocAck      = ack;
  assign bus.allocId       = alloc_id;
  assign bus.axiBReady     = run;
  assign bus.smiRespReady  = rdy_q;
  assign bus.smiRespEofc   = 8'd4;
  assign bus.smiRespData   = data_q;
  assign bus.inFlightCount = infl_q;
  assign bus.errId         = err_q;
endmodule

// File: tb/tb_smi_axi_write_id_pool.sv
// Directed bench: one out-of-order and one in-order pool,
// four IDs each, driven with identical stimulus.
module tb_smi_axi_write_id_pool;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic alloc_req = 1'b0;
  logic [15:0] alloc_tag = '0;
  logic b_valid = 1'b0;
  logic [3:0] b_id = '0;
  logic [1:0] b_resp = '0;
  logic stop = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [63:0] q_o[$];
  logic [63:0] q_i[$];
  logic [15:0] tags [4];
  logic [63:0] exp_o [3];
  logic [63:0] exp_i [3];

  smi_axi_write_id_pool_if #(.AxiIdWidth(4), .DataWidth(64)) bo ();
  smi_axi_write_id_pool_if #(.AxiIdWidth(4), .DataWidth(64)) bi ();

  assign bo.allocReq    = alloc_req;
  assign bo.allocTag    = alloc_tag;
  assign bo.axiBValid   = b_valid;
  assign bo.axiBId      = b_id;
  assign bo.axiBResp    = b_resp;
  assign bo.smiRespStop = stop;
  assign bi.allocReq    = alloc_req;
  assign bi.allocTag    = alloc_tag;
  assign bi.axiBValid   = b_valid;
  assign bi.axiBId      = b_id;
  assign bi.axiBResp    = b_resp;
  assign bi.smiRespStop = stop;

  smi_axi_write_id_pool #(
    .DataIndexSize(3), .AxiIdWidth(4),
    .MaxWriteIds(4), .InOrderResp(1'b0)
  ) u_ooo (.clk(clk), .srst(srst), .bus(bo));

  smi_axi_write_id_pool #(
    .DataIndexSize(3), .AxiIdWidth(4),
    .MaxWriteIds(4), .InOrderResp(1'b1)
  ) u_ino (.clk(clk), .srst(srst), .bus(bi));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!srst && bo.smiRespReady && !stop) q_o.push_back(bo.smiRespData);
    if (!srst && bi.smiRespReady && !stop) q_i.push_back(bi.smiRespData);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fr(input logic [15:0] t,
                                     input logic [1:0] s);
    return {32'h0, t, 6'h0, s, 8'hFE};
  endfunction

  task automatic init_seq(input string nm);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("%s_ackO_c%0d", nm, k), 64'(bo.allocAck), 64'(k == 5));
      chk($sformatf("%s_ackI_c%0d", nm, k), 64'(bi.allocAck), 64'(k == 5));
      if (k < 5) cyc();
    end
  endtask

  initial begin
    tags[0] = 16'h1111;
    tags[1] = 16'h2222;
    tags[2] = 16'h3333;
    tags[3] = 16'h4444;
    exp_o[0] = fr(16'h3333, 2'd0);
    exp_o[1] = fr(16'h1111, 2'd2);
    exp_o[2] = fr(16'h2222, 2'd0);
    exp_i[0] = fr(16'h1111, 2'd2);
    exp_i[1] = fr(16'h2222, 2'd0);
    exp_i[2] = fr(16'h3333, 2'd0);

    repeat (3) cyc();
    chk("rst_ack", 64'(bo.allocAck), 64'd0);
    chk("rst_bready", 64'(bo.axiBReady), 64'd0);
    chk("rst_rdy", 64'(bo.smiRespReady), 64'd0);
    chk("rst_err", 64'(bo.errId), 64'd0);
    chk("rst_infl", 64'(bo.inFlightCount), 64'd0);
    chk("rst_infl_i", 64'(bi.inFlightCount), 64'd0);

    srst = 1'b0;
    init_seq("init");
    chk("run_bready", 64'(bo.axiBReady), 64'd1);

    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1;
      alloc_tag = tags[i];
      chk($sformatf("allocIdO_%0d", i), 64'(bo.allocId), 64'(i));
      chk($sformatf("allocIdI_%0d", i), 64'(bi.allocId), 64'(i));
      cyc();
    end
    alloc_req = 1'b0;
    chk("full_ackO", 64'(bo.allocAck), 64'd0);
    chk("full_ackI", 64'(bi.allocAck), 64'd0);
    chk("full_inflO", 64'(bo.inFlightCount), 64'd4);
    chk("full_inflI", 64'(bi.inFlightCount), 64'd4);

    b_valid = 1'b1;
    b_id = 4'd5;
    b_resp = 2'd0;
    cyc();
    b_valid = 1'b0;
    chk("err5_O", 64'(bo.errId), 64'd1);
    chk("err5_I", 64'(bi.errId), 64'd1);
    cyc();
    chk("err5_endO", 64'(bo.errId), 64'd0);
    chk("err5_endI", 64'(bi.errId), 64'd0);
    chk("err5_inflO", 64'(bo.inFlightCount), 64'd4);
    chk("err5_rdyO", 64'(bo.smiRespReady), 64'd0);

    stop = 1'b1;
    alloc_req = 1'b1;
    alloc_tag = 16'h5555;
    b_valid = 1'b1;
    b_id = 4'd2;
    b_resp = 2'd0;
    cyc();
    b_valid = 1'b0;
    chk("b2_rdy_t1", 64'(bo.smiRespReady), 64'd0);
    chk("b2_ack_t1", 64'(bo.allocAck), 64'd0);
    cyc();
    chk("b2_rdy_t2", 64'(bo.smiRespReady), 64'd1);
    chk("b2_ack_t2", 64'(bo.allocAck), 64'd1);
    chk("b2_allocId", 64'(bo.allocId), 64'd2);
    chk("b2_infl", 64'(bo.inFlightCount), 64'd3);
    chk("b2_data", bo.smiRespData, fr(16'h3333, 2'd0));
    chk("b2_eofc", 64'(bo.smiRespEofc), 64'd4);
    chk("b2_rdyI", 64'(bi.smiRespReady), 64'd0);
    chk("b2_ackI", 64'(bi.allocAck), 64'd0);
    chk("b2_inflI", 64'(bi.inFlightCount), 64'd4);
    alloc_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("stop_rdy_%0d", k), 64'(bo.smiRespReady), 64'd1);
      chk($sformatf("stop_data_%0d", k), bo.smiRespData, fr(16'h3333, 2'd0));
    end
    stop = 1'b0;
    cyc();
    chk("xfer_rdy0", 64'(bo.smiRespReady), 64'd0);
    chk("xfer_cntO", 64'(q_o.size()), 64'd1);
    chk("noframe_I", 64'(q_i.size()), 64'd0);

    b_valid = 1'b1;
    b_id = 4'd0;
    b_resp = 2'd2;
    cyc();
    b_id = 4'd1;
    b_resp = 2'd0;
    cyc();
    b_resp = 2'd3;
    cyc();
    b_valid = 1'b0;
    chk("dup1_errO", 64'(bo.errId), 64'd1);
    chk("dup1_errI", 64'(bi.errId), 64'd1);
    cyc();
    chk("dup1_endO", 64'(bo.errId), 64'd0);
    chk("dup1_endI", 64'(bi.errId), 64'd0);
    repeat (10) cyc();
    chk("b_inflO", 64'(bo.inFlightCount), 64'd1);
    chk("b_inflI", 64'(bi.inFlightCount), 64'd1);
    chk("frames_O", 64'(q_o.size()), 64'd3);
    chk("frames_I", 64'(q_i.size()), 64'd3);
    for (int i = 0; i < 3 && i < q_o.size(); i++)
      chk($sformatf("frameO_%0d", i), q_o[i], exp_o[i]);
    for (int i = 0; i < 3 && i < q_i.size(); i++)
      chk($sformatf("frameI_%0d", i), q_i[i], exp_i[i]);

    stop = 1'b1;
    b_valid = 1'b1;
    b_id = 4'd3;
    b_resp = 2'd1;
    cyc();
    b_valid = 1'b0;
    cyc();
    chk("b3_rdyO", 64'(bo.smiRespReady), 64'd1);
    chk("b3_rdyI", 64'(bi.smiRespReady), 64'd1);
    chk("b3_dataO", bo.smiRespData, fr(16'h4444, 2'd1));
    chk("b3_dataI", bi.smiRespData, fr(16'h4444, 2'd1));
    srst = 1'b1;
    cyc();
    chk("mid_rdyO", 64'(bo.smiRespReady), 64'd0);
    chk("mid_rdyI", 64'(bi.smiRespReady), 64'd0);
    chk("mid_inflO", 64'(bo.inFlightCount), 64'd0);
    chk("mid_inflI", 64'(bi.inFlightCount), 64'd0);
    chk("mid_ackO", 64'(bo.allocAck), 64'd0);
    srst = 1'b0;
    stop = 1'b0;
    init_seq("reinit");
    chk("reinit_idO", 64'(bo.allocId), 64'd0);
    chk("final_framesO", 64'(q_o.size()), 64'd3);
    chk("final_framesI", 64'(q_i.size()), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/smi_axi_write_id_pool.md
Name: smi_axi_write_id_pool

Overview:
Multi-ID write-transaction tracker for SMI-to-AXI write adaptors. It allocates AXI write IDs from a free pool and records the SMI tag per ID. It accepts AXI B responses in any ID order and emits SMI write-response frames. It replaces the single-ID tracking FIFO so that up to MaxWriteIds writes are in flight, with responses either out-of-order or reordered to allocation order.

Parameters:
DataIndexSize, 3, log2 of SMI data bytes; DataWidth = 8 << DataIndexSize (64..512)
AxiIdWidth, 4, AXI ID width
MaxWriteIds, 16, pool size, 1..(1 << AxiIdWidth); IDs used are 0..MaxWriteIds-1
InOrderResp, 0, 0 = respond in B-arrival order; 1 = respond in allocation order

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
allocReq  in  1  dispatcher requests an ID
allocTag  in  16  SMI tag to bind to the allocated ID
allocAck  out  1  ID available; allocation occurs when allocReq & allocAck
allocId  out  AxiIdWidth  allocated ID, valid while allocAck=1
axiBValid  in  1  AXI write response valid
axiBReady  out  1  AXI write response ready
axiBId  in  AxiIdWidth  response ID
axiBResp  in  2  response status
smiRespReady  out  1  SMI response frame valid
smiRespEofc  out  8  constant 8'd4
smiRespData  out  DataWidth  response frame
smiRespStop  in  1  SMI back-pressure
inFlightCount  out  AxiIdWidth+1  number of allocated IDs not yet released
errId  out  1  one-cycle pulse: B with an unexpected ID

Behaviour:
- Reset (srst=1): allocAck=0, axiBReady=0, smiRespReady=0, errId=0, inFlightCount=0. All busy/done bits cleared; free FIFO emptied; order FIFO emptied.
- State Init (entered from reset): pushes IDs 0..MaxWriteIds-1 into the free FIFO, one per cycle, ascending. Lasts exactly MaxWriteIds cycles, then moves to Run. allocAck=0 and axiBReady=0 throughout Init.
- Run, allocation:
  - allocAck = free FIFO non-empty. allocId = head of the free FIFO.
  - On allocation: pop the head; busy[id]<=1; tag[id]<=allocTag; inFlightCount+1.
  - When InOrderResp=1, also push the id into the order FIFO (depth MaxWriteIds; cannot overflow).
- Run, B channel:
  - axiBReady=1 constantly.
  - On axiBValid, if busy[id] & ~done[id]: done[id]<=1, status[id]<=axiBResp.
  - Otherwise (ID not busy, already done, or ≥MaxWriteIds): discard, no table change, errId=1 on the next cycle.
- Response candidate:
  - InOrderResp=0: lowest-numbered ID with done=1.
  - InOrderResp=1: order-FIFO head, only if done[head]=1.
- Output toggle buffer:
  - When smiRespReady=0 and a candidate exists, next cycle: smiRespReady=1 and the frame is loaded.
  - In that same load cycle the candidate's busy and done clear, its ID pushes to the free FIFO, inFlightCount decrements, and (InOrderResp=1) the order FIFO pops.
  - smiRespReady holds while smiRespStop=1. The frame transfers on a cycle with smiRespReady=1 and smiRespStop=0; smiRespReady=0 next cycle.
  - Peak throughput: one response per 2 cycles.
- Frame format:
  - smiRespData[7:0]=8'hFE, [9:8]=status, [15:10]=0, [31:16]=tag, [DataWidth-1:32]=0.
  - smiRespData holds stable while smiRespReady=1.
- Latencies:
  - B accepted at cycle t: earliest smiRespReady=1 at t+2 (done registered at t+1, loaded at t+1 edge to t+2).
  - A released ID is allocatable from the cycle after its push.
- Simultaneous events:
  - Allocation pop and release push in the same cycle: both occur; inFlightCount unchanged. A release into an empty FIFO does not satisfy a same-cycle allocReq.
  - B for an ID being allocated in the same cycle: the ID is not yet busy, so the B is discarded and errId pulses.
  - B setting done and response load in the same cycle: the new done is not a candidate until the next cycle.
- Pool exhaustion: allocAck=0 until a release; no other effect.
- srst mid-operation: all in-flight state is discarded and Init restarts; any pending frame is dropped with smiRespReady=0 the next cycle.

Test Plan:
- Reset with MaxWriteIds=4 -> allocAck first 1 on cycle 5 after srst falls; four allocations return allocId 0,1,2,3; allocAck=0; inFlightCount=4.
- InOrderResp=0: allocate IDs 0,1,2 with tags 0x1111,0x2222,0x3333; B order 2,0,1 (resp 0,2,0) -> frames tag 0x3333 status 0, 0x1111 status 2, 0x2222 status 0; smiRespData[7:0]=0xFE; smiRespEofc=4.
- InOrderResp=1, same stimulus -> frames in order 0x1111, 0x2222, 0x3333; no frame until B for ID 0 arrives.
- B with axiBId=5 while ID 5 is free, and a duplicate B for ID 1 -> errId single-cycle pulse each time; table, inFlightCount and frames unchanged.
- smiRespStop=1 for 10 cycles with a response pending -> smiRespReady and smiRespData stable; one frame transfers once stop falls; then ready=0 for one cycle.
- Pool full (4/4), B for ID 2 then allocReq held -> allocAck rises the cycle after the ID 2 frame is loaded, with allocId=2; assert srst mid-frame -> smiRespReady=0 and inFlightCount=0 the next cycle, and Init repeats.
